dest_reg_pipe: RTL and testbench
================================

Name: dest_reg_pipe

Overview:
- Tracks destination-register specifiers of in-flight instructions through the EX, MEM and WB stages of the pipelined core.
- Sits directly downstream of the decode-stage 5-bit register-specifier latches and consumes their outputs.
- Produces the load-use stall and per-operand forwarding selects used by the decode/execute boundary.
- Also provides the WB write-back specifier and enable to the register file.

Parameters:
- REG_W, 5, width of a register specifier.
- ZERO_REG_HARDWIRED, 1, when 1 specifier 0 never produces a hazard or forward match.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- en  input  1  pipeline advance; 0 freezes the EX, MEM and WB entries
- flush  input  1  kill the instruction entering EX (branch/jump redirect)
- id_wr_en  input  1  decode instruction writes a register
- id_wr_reg  input  REG_W  decode destination specifier
- id_is_load  input  1  decode instruction is a load
- id_rs  input  REG_W  decode source A specifier
- id_rs_used  input  1  source A is read
- id_rt  input  REG_W  decode source B specifier
- id_rt_used  input  1  source B is read
- stall  output  1  load-use hazard; decode must hold
- fwd_a  output  2  source A select: 00 regfile, 01 EX, 10 MEM, 11 WB
- fwd_b  output  2  source B select, same encoding as fwd_a
- wb_wr_en  output  1  WB entry valid and writes
- wb_wr_reg  output  REG_W  WB destination specifier

Behaviour:
- Storage: three entries, EX, MEM and WB, each holding {v, reg[REG_W-1:0], ld}.
- Reset: when rst=0, all entries clear asynchronously to v=0, reg=0, ld=0.
  - Consequently stall=0, fwd_a=fwd_b=00, wb_wr_en=0, wb_wr_reg=0.
  - Reset asserted mid-operation discards all in-flight entries immediately.
- Match rule, for stage S and source X:
  - Match when S.v & X_used & (S.reg==X).
  - Suppressed when ZERO_REG_HARDWIRED and X==0.
- stall (combinational): high when EX.ld matches rs or matches rt.
- fwd_a / fwd_b (combinational):
  - Priority is youngest first: EX match gives 01, else MEM match gives 10, else WB match gives 11, else 00.
  - If stall=1, fwd values are don't-care; the bench ignores them.
- wb_wr_en = WB.v; wb_wr_reg = WB.reg.
- Rising edge with en=1:
  - WB takes MEM, and MEM takes EX.
  - EX takes {id_wr_en, id_wr_reg, id_is_load}, unless stall=1 or flush=1, in which case EX takes a bubble (v=0, ld=0, reg=0).
- Rising edge with en=0:
  - MEM and WB hold.
  - EX holds, except flush=1 still forces an EX bubble; flush overrides en.
- Simultaneous stall and flush: bubble is inserted once; no double effect.
- Latency: an instruction accepted at edge N is in EX after N, in MEM after N+1, and in WB after N+2.
  - It drives wb_wr_en during the cycle following edge N+2.
- Writes with id_wr_en=0 still advance as v=0 entries, so they never match.
- Stall resolves after exactly one en=1 edge, once the load moves to MEM; it must not hold for a second cycle.

Test Plan:
- Reset: assert rst=0 mid-stream with 3 valid entries -> wb_wr_en=0, stall=0, fwd_a=fwd_b=00 immediately, before any clock edge.
- Forward priority: issue writes to r3 on three consecutive cycles, then id_rs=3 with rs_used=1 -> fwd_a=01.
  - Next cycle, with an EX bubble, -> fwd_a=10.
  - One cycle later -> fwd_a=11.
- Load-use: load to r5, then id_rt=5 with rt_used=1 -> stall=1 for exactly one cycle, EX becomes a bubble, then fwd_b=10 and stall=0.
- Zero register: write to r0, then id_rs=0 with rs_used=1 -> fwd_a=00 and stall=0 with ZERO_REG_HARDWIRED=1.
  - Same stimulus with ZERO_REG_HARDWIRED=0 -> fwd_a=01.
- Freeze/flush: en=0 for 2 cycles with valid entries -> wb_wr_reg unchanged.
  - flush=1 during en=0 -> EX.v clears and MEM/WB are unchanged.
- Pipeline drain: write r7 with wr_en=1, then wr_en=0 for 3 cycles -> wb_wr_en=1 with wb_wr_reg=7 exactly 3 cycles after acceptance, then wb_wr_en=0.

Source files
------------

// File: rtl/dest_reg_pipe.sv
// Destination-register tracker for the EX/MEM/WB stages: produces load-use stall,
// operand forwarding selects and the register-file write-back specifier.
module dest_reg_pipe #(
    parameter int unsigned REG_W              = 5,
    parameter bit          ZERO_REG_HARDWIRED = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             id_wr_en,
    input  logic [REG_W-1:0] id_wr_reg,
    input  logic             id_is_load,
    input  logic [REG_W-1:0] id_rs,
    input  logic             id_rs_used,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rt_used,
    output logic             stall,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             wb_wr_en,
    output logic [REG_W-1:0] wb_wr_reg
);

    logic             ex_v_q, ex_v_d, ex_ld_q, ex_ld_d;
    logic [REG_W-1:0] ex_reg_q, ex_reg_d;
    logic             mem_v_q, mem_v_d, mem_ld_q, mem_ld_d;
    logic [REG_W-1:0] mem_reg_q, mem_reg_d;
    logic             wb_v_q, wb_v_d, wb_ld_q, wb_ld_d;
    logic [REG_W-1:0] wb_reg_q, wb_reg_d;

    logic ex_rs, mem_rs, wb_rs;
    logic ex_rt, mem_rt, wb_rt;

    function automatic logic src_match(input logic             v,
                                       input logic [REG_W-1:0] sreg,
                                       input logic             used,
                                       input logic [REG_W-1:0] src);
        logic zero_blk;
        zero_blk = ZERO_REG_HARDWIRED && (src == '0);
        return v && used && (sreg == src) && !zero_blk;
    endfunction

    always_comb begin
        ex_rs  = src_match(ex_v_q,  ex_reg_q,  id_rs_used, id_rs);
        mem_rs = src_match(mem_v_q, mem_reg_q, id_rs_used, id_rs);
        wb_rs  = src_match(wb_v_q,  wb_reg_q,  id_rs_used, id_rs);
        ex_rt  = src_match(ex_v_q,  ex_reg_q,  id_rt_used, id_rt);
        mem_rt = src_match(mem_v_q, mem_reg_q, id_rt_used, id_rt);
        wb_rt  = src_match(wb_v_q,  wb_reg_q,  id_rt_used, id_rt);
    end

    assign stall     = ex_ld_q && (ex_rs || ex_rt);
    assign wb_wr_en  = wb_v_q;
    assign wb_wr_reg = wb_reg_q;

    // Youngest producer wins.
    always_comb begin
        fwd_a = 2'b00;
        if (ex_rs)       fwd_a = 2'b01;
        else if (mem_rs) fwd_a = 2'b10;
        else if (wb_rs)  fwd_a = 2'b11;
        fwd_b = 2'b00;
        if (ex_rt)       fwd_b = 2'b01;
        else if (mem_rt) fwd_b = 2'b10;
        else if (wb_rt)  fwd_b = 2'b11;
    end

    always_comb begin
        ex_v_d    = ex_v_q;
        ex_reg_d  = ex_reg_q;
        ex_ld_d   = ex_ld_q;
        mem_v_d   = mem_v_q;
        mem_reg_d = mem_reg_q;
        mem_ld_d  = mem_ld_q;
        wb_v_d    = wb_v_q;
        wb_reg_d  = wb_reg_q;
        wb_ld_d   = wb_ld_q;
        if (en) begin
            wb_v_d    = mem_v_q;
            wb_reg_d  = mem_reg_q;
            wb_ld_d   = mem_ld_q;
            mem_v_d   = ex_v_q;
            mem_reg_d = ex_reg_q;
            mem_ld_d  = ex_ld_q;
            ex_v_d    = id_wr_en;
            ex_reg_d  = id_wr_reg;
            ex_ld_d   = id_is_load;
        end
        // Flush kills EX even while frozen; a stalled advance inserts one bubble.
        if (flush || (en && stall)) begin
            ex_v_d   = 1'b0;
            ex_reg_d = '0;
            ex_ld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_v_q    <= 1'b0;
            ex_reg_q  <= '0;
            ex_ld_q   <= 1'b0;
            mem_v_q   <= 1'b0;
            mem_reg_q <= '0;
            mem_ld_q  <= 1'b0;
            wb_v_q    <= 1'b0;
            wb_reg_q  <= '0;
            wb_ld_q   <= 1'b0;
        end else begin
            ex_v_q    <= ex_v_d;
            ex_reg_q  <= ex_reg_d;
            ex_ld_q   <= ex_ld_d;
            mem_v_q   <= mem_v_d;
            mem_reg_q <= mem_reg_d;
            mem_ld_q  <= mem_ld_d;
            wb_v_q    <= wb_v_d;
            wb_reg_q  <= wb_reg_d;
            wb_ld_q   <= wb_ld_d;
        end
    end

    // The WB load flag is carried for completeness but no consumer needs it.
    logic unused_wb_ld;
    assign unused_wb_ld = wb_ld_q;

endmodule

// File: tb/tb_dest_reg_pipe.sv
// Bench for dest_reg_pipe: scenario tasks with inline checks plus a write-back
// scoreboard fed when instructions are accepted and drained as WB entries appear.
module tb_dest_reg_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, flush;
    logic       id_wr_en, id_is_load, id_rs_used, id_rt_used;
    logic [4:0] id_wr_reg, id_rs, id_rt;
    logic       stall, wb_wr_en;
    logic [1:0] fwd_a, fwd_b;
    logic [4:0] wb_wr_reg;
    logic       stall_nz, wb_wr_en_nz;
    logic [1:0] fwd_a_nz, fwd_b_nz;
    logic [4:0] wb_wr_reg_nz;

    int checks = 0;
    int errors = 0;
    logic [4:0] sb_q[$];

    always #5 clk = ~clk;

    dest_reg_pipe #(.REG_W(5), .ZERO_REG_HARDWIRED(1'b1)) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg), .id_is_load(id_is_load),
        .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rt(id_rt), .id_rt_used(id_rt_used),
        .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .wb_wr_en(wb_wr_en), .wb_wr_reg(wb_wr_reg)
    );

    dest_reg_pipe #(.REG_W(5), .ZERO_REG_HARDWIRED(1'b0)) dut_nz (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg), .id_is_load(id_is_load),
        .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rt(id_rt), .id_rt_used(id_rt_used),
        .stall(stall_nz), .fwd_a(fwd_a_nz), .fwd_b(fwd_b_nz),
        .wb_wr_en(wb_wr_en_nz), .wb_wr_reg(wb_wr_reg_nz)
    );

    task automatic set_idle();
        en = 1'b1; flush = 1'b0;
        id_wr_en = 1'b0; id_wr_reg = 5'd0; id_is_load = 1'b0;
        id_rs = 5'd0; id_rs_used = 1'b0; id_rt = 5'd0; id_rt_used = 1'b0;
    endtask

    // One clock; pushes the driven write if the scenario says it is accepted and
    // pops the scoreboard whenever an advancing edge lands a valid entry in WB.
    task automatic tick(input bit accept);
        logic       en_s;
        logic [4:0] exp;
        en_s = en;
        if (accept && en && id_wr_en) sb_q.push_back(id_wr_reg);
        @(posedge clk);
        #1;
        if (en_s && wb_wr_en) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_wb: got wb_wr_reg=%0d, expected no write-back", wb_wr_reg);
            end else begin
                exp = sb_q.pop_front();
                if (wb_wr_reg !== exp) begin
                    errors++;
                    $display("FAIL sb_wb: got wb_wr_reg=%0d, expected %0d", wb_wr_reg, exp);
                end
            end
        end
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b0;
        sb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic issue(input logic [4:0] r, input logic ld);
        id_wr_en = 1'b1; id_wr_reg = r; id_is_load = ld;
        tick(1'b1);
        set_idle();
    endtask

    task automatic drain_check(input string name);
        set_idle();
        repeat (3) tick(1'b0);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d pending write-backs, expected 0", name, sb_q.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({stall, fwd_a, fwd_b, wb_wr_en, wb_wr_reg} !== 11'd0) begin
            errors++;
            $display("FAIL reset_state: got %b, expected all zero",
                     {stall, fwd_a, fwd_b, wb_wr_en, wb_wr_reg});
        end
        issue(5'd1, 1'b0);
        issue(5'd2, 1'b0);
        issue(5'd3, 1'b1);
        id_rs = 5'd3; id_rs_used = 1'b1;
        #1;
        checks++;
        if ({stall, wb_wr_en, wb_wr_reg} !== {1'b1, 1'b1, 5'd1}) begin
            errors++;
            $display("FAIL reset_prefill: got stall/wb_en/wb_reg=%b, expected 1/1/00001",
                     {stall, wb_wr_en, wb_wr_reg});
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({stall, fwd_a, fwd_b, wb_wr_en, wb_wr_reg} !== 11'd0) begin
            errors++;
            $display("FAIL reset_async: got %b, expected all zero before any edge",
                     {stall, fwd_a, fwd_b, wb_wr_en, wb_wr_reg});
        end
        sb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        set_idle();
    endtask

    task automatic test_fwd_priority();
        do_reset();
        issue(5'd3, 1'b0);
        issue(5'd3, 1'b0);
        issue(5'd3, 1'b0);
        id_rs = 5'd3; id_rs_used = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0 || fwd_a !== 2'b01 || fwd_b !== 2'b00) begin
            errors++;
            $display("FAIL fwd_ex: got stall=%b fwd_a=%b fwd_b=%b, expected 0/01/00",
                     stall, fwd_a, fwd_b);
        end
        flush = 1'b1;
        tick(1'b0);
        checks++;
        if (fwd_a !== 2'b10) begin
            errors++;
            $display("FAIL fwd_mem: got fwd_a=%b, expected 10", fwd_a);
        end
        tick(1'b0);
        checks++;
        if (fwd_a !== 2'b11) begin
            errors++;
            $display("FAIL fwd_wb: got fwd_a=%b, expected 11", fwd_a);
        end
        drain_check("fwd");
    endtask

    task automatic test_load_use();
        do_reset();
        issue(5'd5, 1'b1);
        id_wr_en = 1'b1; id_wr_reg = 5'd6; id_rt = 5'd5; id_rt_used = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL ldu_stall: got stall=%b, expected 1", stall);
        end
        tick(1'b0);
        checks++;
        if (stall !== 1'b0 || fwd_b !== 2'b10) begin
            errors++;
            $display("FAIL ldu_resolve: got stall=%b fwd_b=%b, expected 0/10", stall, fwd_b);
        end
        tick(1'b1);
        set_idle();
        id_rt = 5'd6; id_rt_used = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0 || fwd_b !== 2'b01) begin
            errors++;
            $display("FAIL ldu_accept: got stall=%b fwd_b=%b, expected 0/01", stall, fwd_b);
        end
        drain_check("ldu");
    endtask

    task automatic test_zero_reg();
        do_reset();
        issue(5'd0, 1'b0);
        id_rs = 5'd0; id_rs_used = 1'b1;
        #1;
        checks++;
        if (fwd_a !== 2'b00 || stall !== 1'b0 || fwd_a_nz !== 2'b01) begin
            errors++;
            $display("FAIL zero_fwd: got fwd_a=%b stall=%b fwd_a_nz=%b, expected 00/0/01",
                     fwd_a, stall, fwd_a_nz);
        end
        set_idle();
        issue(5'd0, 1'b1);
        id_rs = 5'd0; id_rs_used = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0 || stall_nz !== 1'b1) begin
            errors++;
            $display("FAIL zero_stall: got stall=%b stall_nz=%b, expected 0/1", stall, stall_nz);
        end
        drain_check("zero");
    endtask

    task automatic test_freeze_flush();
        do_reset();
        issue(5'd1, 1'b0);
        issue(5'd2, 1'b0);
        issue(5'd3, 1'b0);
        en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick(1'b0);
            checks++;
            if (wb_wr_en !== 1'b1 || wb_wr_reg !== 5'd1) begin
                errors++;
                $display("FAIL freeze_hold: got wb_en=%b wb_reg=%0d, expected 1/1",
                         wb_wr_en, wb_wr_reg);
            end
        end
        id_rs = 5'd3; id_rs_used = 1'b1;
        #1;
        checks++;
        if (fwd_a !== 2'b01) begin
            errors++;
            $display("FAIL freeze_ex: got fwd_a=%b, expected 01", fwd_a);
        end
        flush = 1'b1;
        tick(1'b0);
        void'(sb_q.pop_back());
        flush = 1'b0;
        #1;
        checks++;
        if (fwd_a !== 2'b00 || wb_wr_en !== 1'b1 || wb_wr_reg !== 5'd1) begin
            errors++;
            $display("FAIL flush_frozen: got fwd_a=%b wb_en=%b wb_reg=%0d, expected 00/1/1",
                     fwd_a, wb_wr_en, wb_wr_reg);
        end
        id_rs = 5'd2;
        #1;
        checks++;
        if (fwd_a !== 2'b10) begin
            errors++;
            $display("FAIL flush_mem_kept: got fwd_a=%b, expected 10", fwd_a);
        end
        drain_check("flush");
    endtask

    task automatic test_drain();
        logic exp_en;
        do_reset();
        issue(5'd7, 1'b0);
        for (int k = 0; k <= 3; k++) begin
            if (k > 0) tick(1'b0);
            exp_en = (k == 2);
            checks++;
            if (wb_wr_en !== exp_en || (exp_en && wb_wr_reg !== 5'd7)) begin
                errors++;
                $display("FAIL drain_k%0d: got wb_en=%b wb_reg=%0d, expected %b/7",
                         k, wb_wr_en, wb_wr_reg, exp_en);
            end
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain_sb: got %0d pending write-backs, expected 0", sb_q.size());
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            id_wr_en  = 1'($urandom_range(0, 1));
            id_wr_reg = 5'($urandom_range(0, 31));
            tick(1'b1);
        end
        drain_check("b2b");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        set_idle();
        rst = 1'b1;
        test_reset();
        test_fwd_priority();
        test_load_use();
        test_zero_reg();
        test_freeze_flush();
        test_drain();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
